// File: rtl/sig_mul_seq.sv
// sig_mul_seq: radix-2 shift-add significand multiplier for the FPU multiply path.
// Takes two unsigned significands (double 53-bit or single 24-bit) behind a
// valid/ready handshake and returns the exact product left-aligned in a 128-bit
// word plus the latched precision flag, ready for the rounder.
// Optional build macro SIGMUL_ZERO_SKIP_EN: when defined, a zero operand skips
// the iterative phase and the result (zero) is presented right after accept.

module sig_mul_seq #(
    parameter int SIG_W = 53
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SIG_W-1:0]   a_sig,
    input  logic [SIG_W-1:0]   b_sig,
    input  logic               db_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       fn,
    output logic               db,
    output logic               busy
);

    // Output word width is fixed by the rounder interface.
    localparam int FN_W  = 128;
    localparam int SGL_W = 24;
    localparam int ACC_W = 2 * SIG_W;
    localparam int CNT_W = $clog2(SIG_W + 1);

    // A single-precision product, after only SGL_W shift steps, sits in the
    // accumulator shifted left by (SIG_W - SGL_W); these bounds pick it out.
    localparam int SGL_LO = SIG_W - SGL_W;
    localparam int SGL_HI = SGL_LO + 2 * SGL_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [SIG_W-1:0]   r_mcand;
    logic [SIG_W-1:0]   r_mplr;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic               r_db;
    logic [FN_W-1:0]    r_fn;
    logic               r_dbOut;
    logic               r_outValid;
    logic               r_busy;

    logic               w_accept;
    logic               w_zeroSkip;
    logic               w_lastStep;
    logic [SIG_W-1:0]   w_opA;
    logic [SIG_W-1:0]   w_opB;
    logic [CNT_W-1:0]   w_countLoad;
    logic [SIG_W:0]     w_sum;
    logic [ACC_W-1:0]   w_accNext;
    logic [FN_W-1:0]    w_fnNext;

    // Operand conditioning: single precision keeps only the low 24 bits.
    always_comb begin
        w_opA       = a_sig;
        w_opB       = b_sig;
        w_countLoad = CNT_W'(SIG_W);
        if (!db_in) begin
            w_opA       = {{(SIG_W-SGL_W){1'b0}}, a_sig[SGL_W-1:0]};
            w_opB       = {{(SIG_W-SGL_W){1'b0}}, b_sig[SGL_W-1:0]};
            w_countLoad = CNT_W'(SGL_W);
        end
    end

`ifdef SIGMUL_ZERO_SKIP_EN
    // Zero detect on the conditioned operands so ignored upper bits never matter.
    always_comb begin
        w_zeroSkip = (w_opA == '0) || (w_opB == '0);
    end
`else
    // Without the skip feature zero operands take the full iteration count.
    always_comb begin
        w_zeroSkip = 1'b0;
    end
`endif

    // One shift-add step: add the multiplicand into the high half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    always_comb begin
        w_sum      = {1'b0, r_acc[ACC_W-1:SIG_W]};
        if (r_mplr[0]) begin
            w_sum = {1'b0, r_acc[ACC_W-1:SIG_W]} + {1'b0, r_mcand};
        end
        w_accNext  = {w_sum, r_acc[SIG_W-1:1]};
        w_lastStep = (r_count == CNT_W'(1));
    end

    // Left-align the finished product into the rounder's word format.
    always_comb begin
        w_fnNext = {w_accNext, {(FN_W-ACC_W){1'b0}}};
        if (!r_db) begin
            w_fnNext = {w_accNext[SGL_HI:SGL_LO], {(FN_W-2*SGL_W){1'b0}}};
        end
    end

    // Next-state decode; in_ready comes straight from state and is held low in reset.
    always_comb begin
        w_nextState = r_state;
        in_ready    = (r_state == IDLE) && rst_n;
        w_accept    = in_valid && (r_state == IDLE) && rst_n;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = w_zeroSkip ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_lastStep) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Registered handshake and status flags follow the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_outValid <= (w_nextState == DONE);
            r_busy     <= (w_nextState != IDLE);
        end
    end

    // Datapath: latch operands on accept, iterate in RUN, publish result entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_mplr  <= '0;
            r_acc   <= '0;
            r_count <= '0;
            r_db    <= 1'b0;
            r_fn    <= '0;
            r_dbOut <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mcand <= w_opA;
                        r_mplr  <= w_opB;
                        r_acc   <= '0;
                        r_count <= w_countLoad;
                        r_db    <= db_in;
                        if (w_zeroSkip) begin
                            r_fn    <= '0;
                            r_dbOut <= db_in;
                        end
                    end
                end
                RUN: begin
                    r_acc   <= w_accNext;
                    r_mplr  <= r_mplr >> 1;
                    r_count <= r_count - CNT_W'(1);
                    if (w_lastStep) begin
                        r_fn    <= w_fnNext;
                        r_dbOut <= r_db;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid = r_outValid;
    assign busy      = r_busy;
    assign fn        = r_fn;
    assign db        = r_dbOut;

endmodule

// File: tb/tb_sig_mul_seq.sv
// tb_sig_mul_seq: directed and randomized checks of the sequential significand
// multiplier against an arithmetic product model.

module tb_sig_mul_seq;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [52:0]   a_sig = '0;
   logic [52:0]   b_sig = '0;
   logic          db_in = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [127:0]  fn;
   logic          db;
   logic          busy;

   int testsRun = 0;
   int testsFailed = 0;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   sig_mul_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_sig     (a_sig),
      .b_sig     (b_sig),
      .db_in     (db_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fn        (fn),
      .db        (db),
      .busy      (busy)
   );

   // Counts one comparison and reports it when observed differs from expected.
   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Reference: exact integer product, left-aligned by precision.
   function automatic logic [127:0] modelFn(input logic [52:0] a, input logic [52:0] b, input logic dbl);
      logic [127:0] pa;
      logic [127:0] pb;
      if (dbl) begin
         pa = {75'd0, a};
         pb = {75'd0, b};
         return (pa * pb) << 22;
      end
      pa = {104'd0, a[23:0]};
      pb = {104'd0, b[23:0]};
      return (pa * pb) << 80;
   endfunction

   // Runs one full transaction: accept, latency, result, optional backpressure, handshake.
   task automatic applyStimulus(input logic [52:0] a, input logic [52:0] b, input logic dbl,
                                input int holdCycles, input logic preReady);
      int waitCount;
      int lat;
      logic [127:0] expFn;
      expFn = modelFn(a, b, dbl);
      waitCount = 0;
      while (!in_ready && waitCount < 20) begin
         @(posedge clk); #1;
         waitCount++;
      end
      checkOutput("inReadyIdle", in_ready, 1'b1);
      a_sig = a;
      b_sig = b;
      db_in = dbl;
      in_valid = 1'b1;
      out_ready = preReady;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a_sig = 53'({$urandom(), $urandom()});
      b_sig = 53'({$urandom(), $urandom()});
      db_in = ~dbl;
      checkOutput("busyRun", busy, 1'b1);
      checkOutput("inReadyRun", in_ready, 1'b0);
      checkOutput("outValidRun", out_valid, 1'b0);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("latency", lat, dbl ? 53 : 24);
      checkOutput("fn", fn, expFn);
      checkOutput("db", db, dbl);
      checkOutput("inReadyDone", in_ready, 1'b0);
      if (holdCycles > 0) begin
         out_ready = 1'b0;
         in_valid = 1'b1;
         for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk); #1;
            checkOutput("outValidHold", out_valid, 1'b1);
            checkOutput("fnHold", fn, expFn);
            checkOutput("inReadyHold", in_ready, 1'b0);
         end
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput("outValidDrop", out_valid, 1'b0);
      checkOutput("inReadyBack", in_ready, 1'b1);
      checkOutput("busyIdle", busy, 1'b0);
      checkOutput("fnHeldIdle", fn, expFn);
   endtask

   initial begin
      logic [52:0] ra;
      logic [52:0] rb;
      logic        rdbl;

      // Reset state while rst_n is low.
      #12;
      checkOutput("rstInReady", in_ready, 1'b0);
      checkOutput("rstOutValid", out_valid, 1'b0);
      checkOutput("rstFn", fn, 128'd0);
      checkOutput("rstBusy", busy, 1'b0);
      checkOutput("rstDb", db, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("inReadyAfterRst", in_ready, 1'b1);

      // Directed cases.
      applyStimulus(53'h10000000000000, 53'h10000000000000, 1'b1, 0, 1'b0);
      checkOutput("oneTimesOne", fn, 128'h40000000000000000000000000000000);
      applyStimulus(53'h1FFFFFFFFFFFFF, 53'h1FFFFFFFFFFFFF, 1'b1, 0, 1'b1);
      checkOutput("doubleMax", fn, 128'hFFFFFFFFFFFFF0000000000000400000);
      applyStimulus(53'h1FFFFFFFFFFFFF, 53'h800000, 1'b0, 0, 1'b0);
      checkOutput("singleGarbage", fn, 128'h7FFFFF80000000000000000000000000);
      applyStimulus(53'h1ABCDEF0123456, 53'h13579BDF02468A, 1'b1, 20, 1'b0);
      applyStimulus(53'h0FEDCBA9876543, 53'h00000000C00001, 1'b0, 0, 1'b1);
      applyStimulus(53'h0, 53'h1FFFFFFFFFFFFF, 1'b1, 0, 1'b0);
      checkOutput("zeroOperand", fn, 128'd0);

      // Reset in the middle of a double-precision run.
      applyStimulus(53'h1FFFFFFFFFFFFF, 53'h1FFFFFFFFFFFFF, 1'b1, 0, 1'b0);
      a_sig = 53'h1FFFFFFFFFFFFF;
      b_sig = 53'h1FFFFFFFFFFFFF;
      db_in = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
      end
      checkOutput("midRunBusy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      checkOutput("midRstOutValid", out_valid, 1'b0);
      checkOutput("midRstFn", fn, 128'd0);
      checkOutput("midRstBusy", busy, 1'b0);
      checkOutput("midRstInReady", in_ready, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(53'h18000000000001, 53'h10000000000003, 1'b1, 2, 1'b0);

      // Randomized transactions with random precision, backpressure and early out_ready.
      for (int n = 0; n < 24; n++) begin
         rdbl = 1'($urandom_range(0, 1));
         ra = 53'({$urandom(), $urandom()});
         rb = 53'({$urandom(), $urandom()});
         if ($urandom_range(0, 3) != 0) begin
            ra[52] = 1'b1;
            rb[52] = 1'b1;
            ra[23] = 1'b1;
            rb[23] = 1'b1;
         end
         applyStimulus(ra, rb, rdbl, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
